// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single storage controller (IDLE/ISSUE/WAIT/DONE).
// Optional WAIT timeout with a sticky stuck flag is enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] SRAM_LIMIT     = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  input  logic [31:0] p0_addr,
  output logic        p0_ready,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_valid,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  output logic        p1_ready,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        memory_access,
  output logic        memory_is_writing,
  output logic [31:0] addr,
  output logic [31:0] d_in,
  output logic [3:0]  mem_be,
  input  logic [31:0] d_out,
  input  logic        out_valid,
  input  logic        set_programming_mode,
  output logic        busy,
  output logic        stuck
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        stuck_q, stuck_d;

  logic gnt0, gnt1, can_grant, hs0, hs1, wait_expired;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  // rr_q=0 prefers port 0 on contention; a lone requester always wins.
  assign gnt0      = p0_valid & (~p1_valid | ~rr_q);
  assign gnt1      = p1_valid & (~p0_valid |  rr_q);
  assign can_grant = (state_q == IDLE) & ~set_programming_mode & ~stuck_q & ~rst;
  assign hs0       = can_grant & gnt0;
  assign hs1       = can_grant & gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      stuck_q <= stuck_d;
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign wait_expired = (cnt_q == TO_LAST);
`else
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stuck_d = stuck_q;
`ifdef MEM_ARBITER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (hs0) begin
          state_d = ISSUE;
          rr_d    = 1'b1;
          port_d  = 1'b0;
          we_d    = 1'b0;
          addr_d  = p0_addr;
          wdata_d = '0;
          be_d    = 4'hF;
          rdata_d = '0;
          err_d   = 1'b0;
        end else if (hs1) begin
          rr_d    = 1'b0;
          port_d  = 1'b1;
          we_d    = p1_we;
          addr_d  = p1_addr;
          wdata_d = p1_wdata;
          be_d    = p1_be;
          rdata_d = '0;
          // Writes beyond SRAM are rejected without touching storage.
          if (p1_we && (p1_addr >= SRAM_LIMIT)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
            err_d   = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (set_programming_mode) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = WAIT;
`ifdef MEM_ARBITER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        // Programming mode takes priority over a coincident out_valid.
        if (set_programming_mode) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (we_q) begin
          state_d = DONE;
          err_d   = 1'b0;
        end else if (out_valid) begin
          state_d = DONE;
          err_d   = 1'b0;
          rdata_d = d_out;
        end else if (wait_expired) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
          stuck_d = 1'b1;
        end else begin
`ifdef MEM_ARBITER_TIMEOUT_EN
          cnt_d   = cnt_q + 16'd1;
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic active, in_done;

  always_comb begin
    active            = ~rst & (state_q != IDLE);
    in_done           = ~rst & (state_q == DONE);
    p0_ready          = hs0;
    p1_ready          = hs1;
    memory_access     = ~rst & (state_q == ISSUE);
    memory_is_writing = active & we_q;
    addr              = active ? addr_q  : 32'h0;
    d_in              = active ? wdata_q : 32'h0;
    mem_be            = active ? be_q    : 4'h0;
    p0_rvalid         = in_done & ~port_q;
    p1_rvalid         = in_done &  port_q;
    p0_rdata          = (in_done & ~port_q) ? rdata_q : 32'h0;
    p1_rdata          = (in_done &  port_q) ? rdata_q : 32'h0;
    p0_err            = in_done & ~port_q & err_q;
    p1_err            = in_done &  port_q & err_q;
    busy              = active;
    stuck             = ~rst & stuck_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read/write paths, round-robin, rejects, programming mode, reset.
// The timeout scenario runs only when MEM_ARBITER_TIMEOUT_EN is defined.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int unsigned TB_TO = 8;
`else
  localparam int unsigned TB_TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid;
  logic [31:0] p0_addr;
  logic        p0_ready, p0_rvalid, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_valid, p1_we;
  logic [31:0] p1_addr, p1_wdata;
  logic [3:0]  p1_be;
  logic        p1_ready, p1_rvalid, p1_err;
  logic [31:0] p1_rdata;
  logic        memory_access, memory_is_writing;
  logic [31:0] addr, d_in;
  logic [3:0]  mem_be;
  logic [31:0] d_out;
  logic        out_valid, set_programming_mode, busy, stuck;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(TB_TO), .SRAM_LIMIT(32'h0000_2000)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_ready(p0_ready),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_be(p1_be), .p1_ready(p1_ready), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .memory_access(memory_access), .memory_is_writing(memory_is_writing),
    .addr(addr), .d_in(d_in), .mem_be(mem_be), .d_out(d_out),
    .out_valid(out_valid), .set_programming_mode(set_programming_mode),
    .busy(busy), .stuck(stuck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; caller then drives inputs and settles with #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_valid = 0; p0_addr = 0; p1_valid = 0; p1_we = 0; p1_addr = 0;
    p1_wdata = 0; p1_be = 0; d_out = 0; out_valid = 0; set_programming_mode = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs(); tick(); rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    p0_valid = 1; p0_addr = 32'h100;
    tick(); tick();
    #1;
    chk("rst_ready_gated", {31'd0, p0_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stuck", {31'd0, stuck}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    rst = 0; idle_inputs();
    tick();

    // Single p0 SRAM read, data returned in the WAIT cycle
    p0_valid = 1; p0_addr = 32'h100; #1;
    chk("a_p0_ready", {31'd0, p0_ready}, 32'd1);
    chk("a_p1_ready", {31'd0, p1_ready}, 32'd0);
    tick(); p0_valid = 0; #1;
    chk("a_issue_access", {31'd0, memory_access}, 32'd1);
    chk("a_issue_addr", addr, 32'h100);
    chk("a_issue_be", {28'd0, mem_be}, 32'hF);
    chk("a_issue_we", {31'd0, memory_is_writing}, 32'd0);
    chk("a_issue_ready", {31'd0, p0_ready}, 32'd0);
    tick(); out_valid = 1; d_out = 32'hDEADBEEF; #1;
    chk("a_wait_access", {31'd0, memory_access}, 32'd0);
    chk("a_wait_addr", addr, 32'h100);
    tick(); out_valid = 0; d_out = 0; #1;
    chk("a_p0_rvalid", {31'd0, p0_rvalid}, 32'd1);
    chk("a_p0_rdata", p0_rdata, 32'hDEADBEEF);
    chk("a_p0_err", {31'd0, p0_err}, 32'd0);
    chk("a_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    chk("a_p1_rdata", p1_rdata, 32'd0);
    tick(); #1;
    chk("a_idle_busy", {31'd0, busy}, 32'd0);
    chk("a_idle_addr", addr, 32'd0);

    // Both ports requesting continuously: p0, p1, p0, p1 at 4-cycle spacing
    do_reset();
    p0_valid = 1; p0_addr = 32'h40; p1_valid = 1; p1_addr = 32'h80;
    out_valid = 1; d_out = 32'h1111_2222;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("b%0d_p0_ready", k), {31'd0, p0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("b%0d_p1_ready", k), {31'd0, p1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      tick(); #1;
      chk($sformatf("b%0d_busy_ready", k), {30'd0, p0_ready, p1_ready}, 32'd0);
      tick(); tick(); #1;
      chk($sformatf("b%0d_rvalid", k), {30'd0, p1_rvalid, p0_rvalid},
          (k % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("b%0d_addr", k), addr, (k % 2 == 0) ? 32'h40 : 32'h80);
      tick();
    end
    idle_inputs();

    // p1 write beyond SRAM: rejected without a storage access
    p1_valid = 1; p1_we = 1; p1_addr = 32'h2000; p1_wdata = 32'hA5A5; p1_be = 4'h3; #1;
    chk("c_p1_ready", {31'd0, p1_ready}, 32'd1);
    tick(); idle_inputs(); #1;
    chk("c_no_access", {31'd0, memory_access}, 32'd0);
    chk("c_p1_rvalid", {31'd0, p1_rvalid}, 32'd1);
    chk("c_p1_err", {31'd0, p1_err}, 32'd1);
    chk("c_wr_flag", {31'd0, memory_is_writing}, 32'd1);
    tick(); #1;
    chk("c_idle", {31'd0, busy}, 32'd0);

    // p1 SRAM write: one WAIT cycle, out_valid ignored
    p1_valid = 1; p1_we = 1; p1_addr = 32'h10; p1_wdata = 32'hCAFE0001; p1_be = 4'h3; #1;
    chk("d_p1_ready", {31'd0, p1_ready}, 32'd1);
    tick(); idle_inputs(); #1;
    chk("d_issue_access", {31'd0, memory_access}, 32'd1);
    chk("d_issue_din", d_in, 32'hCAFE0001);
    chk("d_issue_be", {28'd0, mem_be}, 32'h3);
    chk("d_issue_we", {31'd0, memory_is_writing}, 32'd1);
    tick(); #1;
    chk("d_wait_rvalid", {31'd0, p1_rvalid}, 32'd0);
    tick(); #1;
    chk("d_done_rvalid", {31'd0, p1_rvalid}, 32'd1);
    chk("d_done_err", {31'd0, p1_err}, 32'd0);
    tick();

    // Programming mode raised in WAIT together with out_valid: error wins
    p1_valid = 1; p1_we = 0; p1_addr = 32'h4000; #1;
    chk("e_p1_ready", {31'd0, p1_ready}, 32'd1);
    tick(); idle_inputs(); tick(); tick(); #1;
    chk("e_still_wait", {31'd0, busy}, 32'd1);
    set_programming_mode = 1; out_valid = 1; d_out = 32'h12345678;
    tick(); out_valid = 0; d_out = 0; #1;
    chk("e_p1_rvalid", {31'd0, p1_rvalid}, 32'd1);
    chk("e_p1_err", {31'd0, p1_err}, 32'd1);
    chk("e_p1_rdata", p1_rdata, 32'd0);
    tick(); p0_valid = 1; p1_valid = 1; #1;
    chk("e_prog_ready", {30'd0, p0_ready, p1_ready}, 32'd0);
    tick(); idle_inputs();

    // Reset during WAIT drops the transaction
    p1_valid = 1; p1_addr = 32'h4000; #1;
    chk("f_p1_ready", {31'd0, p1_ready}, 32'd1);
    tick(); idle_inputs(); tick();
    rst = 1; #1;
    chk("f_rst_busy", {31'd0, busy}, 32'd0);
    chk("f_rst_addr", addr, 32'd0);
    tick(); rst = 0; #1;
    chk("f_no_rvalid", {31'd0, p1_rvalid}, 32'd0);
    chk("f_after_busy", {31'd0, busy}, 32'd0);
    tick();

`ifdef MEM_ARBITER_TIMEOUT_EN
    // External read never answered: times out after 8 WAIT cycles
    do_reset();
    p0_valid = 1; p0_addr = 32'h4000; #1;
    chk("g_p0_ready", {31'd0, p0_ready}, 32'd1);
    tick(); idle_inputs(); tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("g_wait%0d", i), {30'd0, busy, p0_rvalid}, 32'd2);
      tick();
    end
    #1;
    chk("g_rvalid", {31'd0, p0_rvalid}, 32'd1);
    chk("g_err", {31'd0, p0_err}, 32'd1);
    chk("g_rdata", p0_rdata, 32'd0);
    chk("g_stuck", {31'd0, stuck}, 32'd1);
    tick(); p0_valid = 1; #1;
    chk("g_stuck_ready", {31'd0, p0_ready}, 32'd0);
    chk("g_stuck_hold", {31'd0, stuck}, 32'd1);
    rst = 1; tick(); rst = 0; #1;
    chk("g_stuck_clr", {31'd0, stuck}, 32'd0);
    chk("g_ready_back", {31'd0, p0_ready}, 32'd1);
    idle_inputs();
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
